// File: rtl/int_controller.sv
// -----------------------------------------------------------------------------
// int_controller : vectored interrupt controller with fixed priority.
//
// NUM_CHANNELS request lines are synchronised (2 flops), latched per channel as
// edge or level, masked and arbitrated (channel 0 highest). A single REQ/ACK
// handshake hands the winner to the core together with its vector address.
//
// Optional feature macro: INTC_NESTING_EN
//   defined   : a strictly higher priority channel may interrupt SERVICE
//   undefined : no new request is raised from SERVICE until EOI
//
// Ports
//   CLK, RESETN           clock (rising) / async active-low reset
//   IRQ[NUM_CHANNELS]     raw asynchronous interrupt lines, active high
//   INT_REQ / INT_ACK     handshake to/from the core
//   INT_VECTOR, INT_ID    vector and index of the acknowledged channel
//   REG_CS, REG_ADDR,     word-addressed register port:
//   REG_WRN, REG_DIN,       0 MASK (RW), 1 MODE (RW, 1=edge),
//   REG_DOUT                2 PENDING (R, W1C edge bits), 3 INSERVICE (R, write=EOI)
// -----------------------------------------------------------------------------

// Per-channel synchroniser and pending latch.
module int_channel (
    input  logic gclk,
    input  logic grst_n,
    input  logic irq,
    input  logic edge_mode,
    input  logic clr,
    output logic pend
);
    logic s1, s2, s2_d;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
            pend <= 1'b0;
        end else begin
            s1   <= irq;
            s2   <= s1;
            s2_d <= s2;
            // a fresh edge beats a simultaneous clear
            if (edge_mode) pend <= (pend & ~clr) | (s2 & ~s2_d);
            else           pend <= s2;
        end
    end
endmodule

module int_controller #(
    parameter int          NUM_CHANNELS  = 4,
    parameter logic [15:0] VECTOR_BASE   = 16'h0004,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0002
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic [NUM_CHANNELS-1:0] IRQ,
    output logic                    INT_REQ,
    input  logic                    INT_ACK,
    output logic [15:0]             INT_VECTOR,
    output logic [3:0]              INT_ID,
    input  logic                    REG_CS,
    input  logic [1:0]              REG_ADDR,
    input  logic                    REG_WRN,
    input  logic [15:0]             REG_DIN,
    output logic [15:0]             REG_DOUT
);
    localparam int N = NUM_CHANNELS;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [15:0] din;
    } reg_req_t;

    state_t   state_q, state_d;
    reg_req_t rq;

    logic [N-1:0] mask_q, mode_q, ins_q, ins_d;
    logic [N-1:0] pend, w1c, ack_oh, ack_clr, elig, ins_low;
    logic [3:0]   win, win_q, ack_win;
    logic         any_elig, ack_fire, eoi;
    logic [15:0]  rd_val, vec_d;

    assign rq.wr   = REG_CS & ~REG_WRN;
    assign rq.addr = REG_ADDR;
    assign rq.din  = REG_DIN;

    assign w1c = (rq.wr && rq.addr == 2'd2) ? rq.din[N-1:0] : '0;
    assign eoi = rq.wr && rq.addr == 2'd3;

    int_channel u_ch [N-1:0] (
        .gclk      (CLK),
        .grst_n    (RESETN),
        .irq       (IRQ),
        .edge_mode (mode_q),
        .clr       (w1c | ack_clr),
        .pend      (pend)
    );

    // A channel is blocked by any in-service channel at equal or higher priority.
    for (genvar i = 0; i < N; i++) begin : g_elig
        assign elig[i] = pend[i] & mask_q[i] & ~(|ins_q[i:0]);
    end

    always_comb begin
        win = '0;
        for (int i = N - 1; i >= 0; i--)
            if (elig[i]) win = 4'(i);
    end

    assign any_elig = |elig;
    assign ack_fire = (state_q == S_REQ) && INT_ACK;
    // if eligibility vanished in the ACK cycle, the last valid winner is served
    assign ack_win  = any_elig ? win : win_q;

    always_comb begin
        for (int i = 0; i < N; i++)
            ack_oh[i] = ack_fire && (ack_win == 4'(i));
    end

    assign ack_clr = ack_oh & mode_q;
    assign vec_d   = VECTOR_BASE + VECTOR_STRIDE * {12'd0, ack_win};

    // EOI retires the lowest-index (highest priority) bit, then ACK sets
    assign ins_low = ins_q & (~ins_q + N'(1));
    assign ins_d   = (eoi ? (ins_q & ~ins_low) : ins_q) | ack_oh;

    always_comb begin
        rd_val = '0;
        case (REG_ADDR)
            2'd0:    rd_val[N-1:0] = mask_q;
            2'd1:    rd_val[N-1:0] = mode_q;
            2'd2:    rd_val[N-1:0] = pend;
            default: rd_val[N-1:0] = ins_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            mode_q     <= '0;
            ins_q      <= '0;
            win_q      <= '0;
            INT_ID     <= '0;
            INT_VECTOR <= '0;
            REG_DOUT   <= '0;
        end else begin
            state_q <= state_d;
            ins_q   <= ins_d;
            if (rq.wr && rq.addr == 2'd0) mask_q <= rq.din[N-1:0];
            if (rq.wr && rq.addr == 2'd1) mode_q <= rq.din[N-1:0];
            if (any_elig) win_q <= win;
            if (ack_fire) begin
                INT_ID     <= ack_win;
                INT_VECTOR <= vec_d;
            end
            if (REG_CS) REG_DOUT <= rd_val;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:
                if (any_elig) state_d = S_REQ;
            S_REQ:
                if (INT_ACK)        state_d = S_SERVICE;
                else if (!any_elig) state_d = (|ins_q) ? S_SERVICE : S_IDLE;
            S_SERVICE: begin
`ifdef INTC_NESTING_EN
                if (any_elig)    state_d = S_REQ;
                else if (~|ins_q) state_d = S_IDLE;
`else
                if (~|ins_q) state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign INT_REQ = (state_q == S_REQ);
endmodule

// File: tb/tb_int_controller.sv
module tb_int_controller;
    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic [3:0]  IRQ = '0;
    logic        INT_ACK = 1'b0;
    logic        REG_CS = 1'b0;
    logic [1:0]  REG_ADDR = '0;
    logic        REG_WRN = 1'b1;
    logic [15:0] REG_DIN = '0;
    logic        INT_REQ;
    logic [15:0] INT_VECTOR;
    logic [3:0]  INT_ID;
    logic [15:0] REG_DOUT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  id;
        logic [15:0] vec;
    } ack_exp_t;

    ack_exp_t    ack_q[$];
    logic [15:0] rd_q[$];

    int_controller dut (
        .CLK(CLK), .RESETN(RESETN), .IRQ(IRQ), .INT_REQ(INT_REQ), .INT_ACK(INT_ACK),
        .INT_VECTOR(INT_VECTOR), .INT_ID(INT_ID), .REG_CS(REG_CS), .REG_ADDR(REG_ADDR),
        .REG_WRN(REG_WRN), .REG_DIN(REG_DIN), .REG_DOUT(REG_DOUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        REG_CS = 1'b1; REG_WRN = 1'b0; REG_ADDR = a; REG_DIN = d;
        tick(1);
        REG_CS = 1'b0; REG_WRN = 1'b1;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] e;
        rd_q.push_back(exp);
        REG_CS = 1'b1; REG_WRN = 1'b1; REG_ADDR = a;
        tick(1);
        REG_CS = 1'b0;
        e = rd_q.pop_front();
        check(tag, REG_DOUT, e);
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (INT_REQ !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, {15'd0, INT_REQ}, 16'd1);
    endtask

    task automatic no_req(input string tag, input int n);
        logic seen = 1'b0;
        repeat (n) begin
            tick(1);
            if (INT_REQ !== 1'b0) seen = 1'b1;
        end
        check(tag, {15'd0, seen}, 16'd0);
    endtask

    task automatic ack_check(input string tag, input logic [3:0] id, input logic [15:0] vec);
        ack_exp_t e;
        ack_q.push_back('{id, vec});
        INT_ACK = 1'b1;
        tick(1);
        INT_ACK = 1'b0;
        e = ack_q.pop_front();
        check({tag, "_req_low"}, {15'd0, INT_REQ}, 16'd0);
        check({tag, "_id"}, {12'd0, INT_ID}, {12'd0, e.id});
        check({tag, "_vec"}, INT_VECTOR, e.vec);
    endtask

    task automatic do_reset();
        RESETN = 1'b0; IRQ = '0; INT_ACK = 1'b0; REG_CS = 1'b0; REG_WRN = 1'b1;
        #12;
        RESETN = 1'b1;
        tick(1);
    endtask

    initial begin
        // reset state
        #1;
        check("rst_req", {15'd0, INT_REQ}, 16'd0);
        check("rst_vec", INT_VECTOR, 16'd0);
        check("rst_id", {12'd0, INT_ID}, 16'd0);
        check("rst_dout", REG_DOUT, 16'd0);
        #12;
        RESETN = 1'b1;
        tick(1);
        rd_check("rst_mask", 2'd0, 16'h0000);
        rd_check("rst_mode", 2'd1, 16'h0000);
        rd_check("rst_pend", 2'd2, 16'h0000);
        rd_check("rst_ins", 2'd3, 16'h0000);

        // single edge pulse on ch2, exact 4-edge latency
        wr(2'd0, 16'h000F);
        wr(2'd1, 16'h000F);
        IRQ = 4'b0100;
        tick(1);
        IRQ = 4'b0000;
        check("lat_e1", {15'd0, INT_REQ}, 16'd0);
        tick(1);
        check("lat_e2", {15'd0, INT_REQ}, 16'd0);
        tick(1);
        check("lat_e3", {15'd0, INT_REQ}, 16'd0);
        tick(1);
        check("lat_e4", {15'd0, INT_REQ}, 16'd1);
        ack_check("ch2", 4'd2, 16'h0008);
        rd_check("ch2_ins", 2'd3, 16'h0004);
        rd_check("ch2_pend", 2'd2, 16'h0000);
        wr(2'd3, 16'h0000);
        rd_check("ch2_eoi", 2'd3, 16'h0000);

        // ch1 and ch3 together: priority, then ch3 after EOI
        IRQ = 4'b1010;
        wait_req("pri_req1", 20);
        ack_check("pri_ch1", 4'd1, 16'h0006);
        no_req("pri_blocked", 8);
        wr(2'd3, 16'h0000);
        wait_req("pri_req2", 20);
        ack_check("pri_ch3", 4'd3, 16'h000A);
        wr(2'd3, 16'h0000);
        IRQ = 4'b0000;
        no_req("pri_quiet", 6);

        // level mode on ch0, masked away while in REQ
        do_reset();
        wr(2'd0, 16'h000F);
        wr(2'd1, 16'h000E);
        IRQ = 4'b0001;
        wait_req("lvl_req", 20);
        wr(2'd0, 16'h0000);
        tick(1);
        check("lvl_mask_drop", {15'd0, INT_REQ}, 16'd0);
        no_req("lvl_idle", 3);
        wr(2'd0, 16'h0001);
        wait_req("lvl_restore", 10);
        ack_check("lvl_ch0", 4'd0, 16'h0004);
        rd_check("lvl_pend_kept", 2'd2, 16'h0001);
        IRQ = 4'b0000;
        wr(2'd3, 16'h0000);

        // edge set and W1C in the same cycle: set wins
        do_reset();
        wr(2'd1, 16'h0001);
        IRQ = 4'b0001;
        tick(2);
        wr(2'd2, 16'h0001);
        rd_check("w1c_race", 2'd2, 16'h0001);
        wr(2'd2, 16'h0001);
        rd_check("w1c_clear", 2'd2, 16'h0000);
        wr(2'd0, 16'hFFFF);
        rd_check("mask_upper", 2'd0, 16'h000F);
        wr(2'd1, 16'hFFF0);
        rd_check("mode_upper", 2'd1, 16'h0000);
        IRQ = 4'b0000;

        // ch0 edge while ch3 is in service
        do_reset();
        wr(2'd0, 16'h000F);
        wr(2'd1, 16'h000F);
        IRQ = 4'b1000;
        wait_req("nest_req3", 20);
        ack_check("nest_ch3", 4'd3, 16'h000A);
        IRQ = 4'b1001;
`ifdef INTC_NESTING_EN
        wait_req("nest_req0", 20);
        ack_check("nest_ch0", 4'd0, 16'h0004);
        rd_check("nest_ins9", 2'd3, 16'h0009);
        wr(2'd3, 16'h0000);
        rd_check("nest_ins8", 2'd3, 16'h0008);
        wr(2'd3, 16'h0000);
`else
        no_req("nest_none", 10);
        rd_check("nest_ins8", 2'd3, 16'h0008);
        wr(2'd3, 16'h0000);
        wait_req("nest_req0", 20);
        ack_check("nest_ch0", 4'd0, 16'h0004);
        rd_check("nest_ins1", 2'd3, 16'h0001);
        wr(2'd3, 16'h0000);
`endif
        IRQ = 4'b0000;

        // async reset in the middle of a handshake
        do_reset();
        wr(2'd0, 16'h000F);
        wr(2'd1, 16'h000F);
        IRQ = 4'b0010;
        wait_req("mid_req1", 20);
        ack_check("mid_ch1", 4'd1, 16'h0006);
        wr(2'd3, 16'h0000);
        IRQ = 4'b0100;
        wait_req("mid_req2", 20);
        rd_check("mid_mask", 2'd0, 16'h000F);
        RESETN = 1'b0;
        #1;
        check("mid_req_drop", {15'd0, INT_REQ}, 16'd0);
        check("mid_id", {12'd0, INT_ID}, 16'd0);
        check("mid_vec", INT_VECTOR, 16'd0);
        check("mid_dout", REG_DOUT, 16'd0);
        IRQ = 4'b0000;
        #10;
        RESETN = 1'b1;
        tick(1);
        rd_check("post_mask", 2'd0, 16'h0000);
        rd_check("post_mode", 2'd1, 16'h0000);
        rd_check("post_pend", 2'd2, 16'h0000);
        rd_check("post_ins", 2'd3, 16'h0000);
        check("post_req", {15'd0, INT_REQ}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Parametrised, vectored interrupt controller; successor to the core's fixed two-line INT0/INT1 inputs.
- Synchronises NUM_CHANNELS external request lines and latches them per channel as edge or level.
- Applies mask and fixed priority; channel 0 is highest priority.
- Issues a single request/acknowledge handshake to the core and supplies a 16-bit vector address.
- Sits between board interrupt pins and the core; configured through a small word-addressed register port on the data bus.

Parameters:
NUM_CHANNELS, 4, number of interrupt inputs (1..16)
VECTOR_BASE, 16'h0004, vector address of channel 0
VECTOR_STRIDE, 16'h0002, address increment per channel

Ports:
CLK  in  1  system clock, rising edge
RESETN  in  1  asynchronous active-low reset
IRQ  in  NUM_CHANNELS  raw asynchronous interrupt lines, active high
INT_REQ  out  1  interrupt request to core
INT_ACK  in  1  one-cycle acknowledge from core, sampled at the FETCH boundary
INT_VECTOR  out  16  vector of the acknowledged channel
INT_ID  out  4  index of the acknowledged channel
REG_CS  in  1  register port select
REG_ADDR  in  2  register index
REG_WRN  in  1  active-low write strobe, 1-cycle
REG_DIN  in  16  write data
REG_DOUT  out  16  read data, registered

Behaviour:
- Reset (RESETN low, async): INT_REQ=0, INT_VECTOR=0, INT_ID=0, REG_DOUT=0; MASK, MODE, PENDING, INSERVICE, synchronisers and state all 0. State goes to IDLE. Reset mid-handshake drops INT_REQ immediately.
- Registers (bits above NUM_CHANNELS read 0, ignore writes):
  - 0 MASK: RW, 1=enabled.
  - 1 MODE: RW, 1=edge, 0=level.
  - 2 PENDING: R; write-1-to-clear edge bits.
  - 3 INSERVICE: R; any write = EOI, clears the lowest-index set bit.
- Register write: takes effect on the rising edge where REG_CS=1 and REG_WRN=0.
- Register read: REG_DOUT updates every cycle from REG_ADDR when REG_CS=1; otherwise it holds.
- Input path: 2-flop synchroniser per line.
  - Edge mode: PENDING set on a 0->1 transition of the synchronised value.
  - Level mode: PENDING mirrors the synchronised value.
- Latency: IRQ rise to INT_REQ high is exactly 4 rising edges (2 synchroniser, 1 pending, 1 state).
- Eligible channel: PENDING & MASK, and no INSERVICE bit at equal or higher priority. The winner is the lowest eligible index.
- State machine:
  - IDLE -> REQ: when any channel is eligible. Registers INT_REQ=1.
  - REQ -> SERVICE on INT_ACK:
    - INT_ID=winner.
    - INT_VECTOR = VECTOR_BASE + winner*VECTOR_STRIDE, mod 2^16.
    - Winner's INSERVICE bit set; winner's edge PENDING bit cleared.
    - INT_REQ=0 on the next edge.
    - The winner is re-evaluated each cycle in REQ; the vector reflects the winner at the ACK cycle.
  - REQ -> IDLE with INT_REQ=0: when nothing is eligible (mask cleared or level dropped) and INT_ACK=0. If INT_ACK=1 in the same cycle, the ACK wins using the previous cycle's winner.
  - SERVICE -> IDLE: when INSERVICE becomes 0.
- INT_ACK outside REQ: ignored.
- Simultaneous edge-set and W1C on the same bit: set wins.
- Simultaneous EOI and ACK: EOI clears first, then ACK sets.
- MASK or MODE change never alters INSERVICE.

Optional Feature:
- Macro: INTC_NESTING_EN.
- Defined: SERVICE also transitions to REQ when a channel of strictly higher priority than every INSERVICE bit is eligible. Multiple INSERVICE bits may be set; EOI clears the highest-priority one.
- Undefined: at most one INSERVICE bit is ever set. No request is raised from SERVICE until EOI, regardless of priority.

Test Plan:
- Reset, MASK=0xF, MODE=0xF; pulse IRQ[2] for 1 cycle -> INT_REQ high after 4 edges. On ACK: INT_ID=2, INT_VECTOR=0x0008, INSERVICE=0x4, PENDING=0x0.
- IRQ[1] and IRQ[3] rise in the same cycle -> ACK gives INT_ID=1, VECTOR=0x0006. After EOI, a second REQ gives INT_ID=3, VECTOR=0x000A.
- Level mode on ch0 (MODE=0xE), IRQ[0] held high, MASK written 0 while in REQ with no ACK -> INT_REQ falls next edge, state IDLE. MASK=1 restores REQ.
- Edge arrives in the same cycle as a W1C of PENDING bit 0 -> PENDING reads 0x0001.
- With INTC_NESTING_EN: ch3 in service, IRQ[0] edge -> second REQ, ACK gives INSERVICE=0x9. EOI leaves 0x8. Without the macro: no REQ until EOI.
- RESETN asserted while INT_REQ=1 -> INT_REQ=0 with no clock edge; all registers read 0 afterwards.
